lmsm_sequencer: RTL and testbench
=================================

Name: lmsm_sequencer

Overview:
Sequences the 3-bit register-index walk for multi-register load/store (LM/SM) instructions. It walks an 8-bit register list, issues one memory access per set bit, and routes data between the register file and memory. It replaces the free-running index counter with a skip-capable, handshaked controller. It sits between the decode/control FSM (start/done) and the memory port and register-file ports.

Parameters:
ADDR_W, 16, memory address width
DATA_W, 16, register/memory data width
ADDR_STEP, 1, address increment per transferred register (word addressing)

Ports:
lmsm_clock  in  1  rising-edge clock
lmsm_reset_n  in  1  asynchronous active-low reset
start  in  1  1-cycle request to begin a sequence; sampled only in IDLE
is_load  in  1  1 = LM (mem->RF), 0 = SM (RF->mem); latched on start
reg_list  in  8  bit i set = transfer register i; latched on start
base_addr  in  ADDR_W  first memory address; latched on start
mem_ready  in  1  memory accepts/completes the current access this cycle
mem_rdata  in  DATA_W  memory read data, valid when mem_ready=1 during a read
rf_rdata  in  DATA_W  register-file read data for rf_raddr
busy  out  1  high in every state except IDLE
done  out  1  1-cycle pulse, sequence complete
mem_rd  out  1  read request (LM access)
mem_wr  out  1  write request (SM access)
mem_addr  out  ADDR_W  current access address
mem_wdata  out  DATA_W  equals rf_rdata (combinational pass-through)
rf_raddr  out  3  current register index
rf_we  out  1  register-file write enable
rf_waddr  out  3  equals current index
rf_wdata  out  DATA_W  equals mem_rdata (pass-through)
xfer_count  out  4  registers transferred so far (0..8)
last  out  1  high during the access for the final set bit

Behaviour:
- Reset (async, lmsm_reset_n=0): state=IDLE. busy, done, mem_rd, mem_wr, rf_we, last = 0. mem_addr, idx, xfer_count, remaining mask = 0. Mid-sequence reset aborts immediately; no further requests are issued.
- States: IDLE, SCAN, ACCESS, DONE. All control outputs are Moore outputs of registered state, except rf_we.
- IDLE: on start=1, latch reg_list into remaining, is_load, and addr<=base_addr; clear xfer_count; go to SCAN. start is ignored in all other states.
- SCAN (1 cycle): if remaining==0, go to DONE. Otherwise idx<=index of the lowest set bit of remaining and go to ACCESS. Zero bits cost no cycles.
- ACCESS: mem_rd=is_load, mem_wr=!is_load, mem_addr=addr, rf_raddr=rf_waddr=idx. last = (remaining has exactly one bit set). Hold all outputs stable until mem_ready=1.
  - rf_we = is_load & mem_ready (combinational, ACCESS only).
  - On the edge where mem_ready=1: clear remaining[idx]; addr<=addr+ADDR_STEP (mod 2^ADDR_W, wrap silently); xfer_count++; go to SCAN.
- DONE: done=1 for exactly one cycle; busy=1; then go to IDLE.
- Timing with mem_ready tied high:
  - start sampled at edge 0; first ACCESS in cycle 2.
  - N set bits: done is high in cycle 2N+2.
  - Empty list: done in cycle 2.
- mem_ready while not in ACCESS: ignored.
- mem_rd and mem_wr are never both high.

Decomposition:
- Shared package: state encoding constants (IDLE/SCAN/ACCESS/DONE) and the 3-bit register-index width constant. Both are also used by the decode FSM.
- Sub-module lowest_set_bit8: 8-bit priority encoder returning index[2:0] and a valid (any-set) flag. Instantiated once, on remaining.

Test Plan:
1. LM, reg_list=8'hFF, base=16'h0040, ready tied high -> 8 reads at addresses 0x40..0x47, rf_waddr 0..7, rf_we once each, last only on idx 7, done in cycle 18, xfer_count=8.
2. SM, reg_list=8'b1010_0010, base=16'h0100 -> writes at idx 1,5,7 to 0x100,0x101,0x102; mem_wdata tracks rf_rdata; done in cycle 8.
3. reg_list=0 -> no mem_rd/mem_wr, done pulse in cycle 2, xfer_count=0.
4. LM, reg_list=8'h01, mem_ready low for 3 cycles -> mem_rd, mem_addr, and idx held 4 cycles; rf_we only in the ready cycle.
5. base=16'hFFFF, reg_list=8'h03 -> addresses 0xFFFF then 0x0000.
6. Reset asserted during the second ACCESS of an 8'hFF LM -> all outputs 0 asynchronously. A new start after release runs a clean sequence. start pulsed while busy is ignored.

Source files
------------

// File: rtl/lmsm_sequencer_pkg.sv
// Shared constants for the LM/SM register-walk sequencer and the decode FSM.
// State codes are plain localparams so legacy decode logic can compare against them.
package lmsm_sequencer_pkg;

   localparam int IDX_W   = 3;
   localparam int STATE_W = 2;

   localparam logic [STATE_W-1:0] ST_IDLE   = 2'd0;
   localparam logic [STATE_W-1:0] ST_SCAN   = 2'd1;
   localparam logic [STATE_W-1:0] ST_ACCESS = 2'd2;
   localparam logic [STATE_W-1:0] ST_DONE   = 2'd3;

   // True when exactly one register is still pending.
   function automatic logic single_bit8(input logic [7:0] v);
      return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
   endfunction

endpackage

// File: rtl/lmsm_sequencer_lowest_set_bit8.sv
// 8-bit priority encoder: index of the lowest set bit, plus an any-set flag.
module lowest_set_bit8
   import lmsm_sequencer_pkg::*;
(
   input  logic [7:0]       bits,
   output logic [IDX_W-1:0] index,
   output logic             valid
);

   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      index = '0;
      // Walk downward so the lowest set bit is the last (winning) assignment.
      for (int i = 7; i >= 0; i--) begin
         if (bits[i]) index = IDX_W'(i);
      end
   end

   assign valid = |bits;

endmodule

// File: rtl/lmsm_sequencer.sv
// LM/SM sequencer: walks the latched register list, one handshaked memory access
// per set bit, skipping clear bits at no cost, then pulses done.
module lmsm_sequencer
   import lmsm_sequencer_pkg::*;
#(
   parameter int ADDR_W    = 16,
   parameter int DATA_W    = 16,
   parameter int ADDR_STEP = 1
) (
   input  logic              lmsm_clock,
   input  logic              lmsm_reset_n,
   input  logic              start,
   input  logic              is_load,
   input  logic [7:0]        reg_list,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic [DATA_W-1:0] rf_rdata,
   output logic              busy,
   output logic              done,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [IDX_W-1:0]  rf_raddr,
   output logic              rf_we,
   output logic [IDX_W-1:0]  rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic [3:0]        xfer_count,
   output logic              last
);

   localparam logic [ADDR_W-1:0] STEP = ADDR_W'(ADDR_STEP);

   logic [STATE_W-1:0] state;
   logic [7:0]         remaining;
   logic               load_q;
   logic [ADDR_W-1:0]  addr;
   logic [IDX_W-1:0]   idx;
   logic [IDX_W-1:0]   lsb_idx;
   logic               lsb_valid;
   logic               in_access;

   lowest_set_bit8 u_lsb (
      .bits  (remaining),
      .index (lsb_idx),
      .valid (lsb_valid)
   );

   always_ff @(posedge lmsm_clock or negedge lmsm_reset_n) begin
      if (!lmsm_reset_n) begin
         state      <= ST_IDLE;
         remaining  <= '0;
         load_q     <= 1'b0;
         addr       <= '0;
         idx        <= '0;
         xfer_count <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register
         // samples pre-edge values regardless of statement order.
         case (state)
            ST_IDLE: begin
               if (start) begin
                  remaining  <= reg_list;
                  load_q     <= is_load;
                  addr       <= base_addr;
                  xfer_count <= '0;
                  state      <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               if (!lsb_valid) begin
                  state <= ST_DONE;
               end else begin
                  idx   <= lsb_idx;
                  state <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               // Hold address/index until the memory completes the access.
               if (mem_ready) begin
                  remaining[idx] <= 1'b0;
                  addr           <= addr + STEP;
                  xfer_count     <= xfer_count + 4'd1;
                  state          <= ST_SCAN;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign in_access = (state == ST_ACCESS);
   assign busy      = (state != ST_IDLE);
   assign done      = (state == ST_DONE);
   assign mem_rd    = in_access &  load_q;
   assign mem_wr    = in_access & ~load_q;
   assign last      = in_access & single_bit8(remaining);
   assign rf_we     = in_access & load_q & mem_ready;

   assign mem_addr  = addr;
   assign rf_raddr  = idx;
   assign rf_waddr  = idx;
   assign mem_wdata = rf_rdata;
   assign rf_wdata  = mem_rdata;

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Bench for lmsm_sequencer: directed table, stall/reset sequences, and random lists
// checked cycle by cycle against a timeline model built from the sequencing rules.
module tb_lmsm_sequencer;

   logic        lmsm_clock = 1'b0;
   logic        lmsm_reset_n = 1'b0;
   logic        start = 1'b0, is_load = 1'b0, mem_ready = 1'b0;
   logic [7:0]  reg_list = '0;
   logic [15:0] base_addr = '0, mem_rdata = '0, rf_rdata = '0;
   logic        busy, done, mem_rd, mem_wr, rf_we, last;
   logic [15:0] mem_addr, mem_wdata, rf_wdata;
   logic [2:0]  rf_raddr, rf_waddr;
   logic [3:0]  xfer_count;

   lmsm_sequencer #(.ADDR_W(16), .DATA_W(16), .ADDR_STEP(1)) dut (
      .lmsm_clock(lmsm_clock), .lmsm_reset_n(lmsm_reset_n), .start(start),
      .is_load(is_load), .reg_list(reg_list), .base_addr(base_addr),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata), .rf_rdata(rf_rdata),
      .busy(busy), .done(done), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .rf_raddr(rf_raddr),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .xfer_count(xfer_count), .last(last)
   );

   always #5 lmsm_clock = ~lmsm_clock;

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   // Expected per-cycle behaviour; element 0 is the cycle after start is sampled.
   typedef struct {
      bit          busy, done, rd, wr, we, last;
      logic [15:0] addr;
      logic [2:0]  idx;
      logic [3:0]  xfer;
   } cyc_t;

   cyc_t exp_q[$];
   bit   ready_seq[256];

   int          st_done_cyc, st_rd, st_wr, st_we, st_last, st_done_n;
   logic [15:0] st_last_addr;

   task automatic fill_ready(input bit random_mode);
      for (int i = 0; i < 256; i++)
         ready_seq[i] = (!random_mode || i >= 100) ? 1'b1 : ($urandom_range(0, 2) != 0);
   endtask

   // Timeline: SCAN cycle, then per set bit an access lasting until ready, then SCAN;
   // after the last SCAN comes one DONE cycle and an IDLE cycle.
   task automatic build_model(input bit load, input logic [7:0] list, input logic [15:0] base);
      int   set_idx[$];
      int   t;
      cyc_t r;
      exp_q.delete();
      for (int i = 0; i < 8; i++) if (list[i]) set_idx.push_back(i);
      r = '{default: 0}; r.busy = 1; exp_q.push_back(r); t = 1;
      for (int k = 0; k < set_idx.size(); k++) begin
         do begin
            t++;
            r = '{default: 0};
            r.busy = 1; r.rd = load; r.wr = !load; r.we = load && ready_seq[t];
            r.last = (k == set_idx.size() - 1);
            r.addr = 16'(int'(base) + k); r.idx = 3'(set_idx[k]); r.xfer = 4'(k);
            exp_q.push_back(r);
         end while (!ready_seq[t]);
         t++;
         r = '{default: 0}; r.busy = 1; r.xfer = 4'(k + 1); exp_q.push_back(r);
      end
      r = '{default: 0}; r.busy = 1; r.done = 1; r.xfer = 4'(set_idx.size()); exp_q.push_back(r);
      r = '{default: 0}; r.xfer = 4'(set_idx.size()); exp_q.push_back(r);
   endtask

   task automatic run_seq(input bit load, input logic [7:0] list, input logic [15:0] base,
                          input bit noisy);
      cyc_t e;
      int   t;
      build_model(load, list, base);
      st_done_cyc = -1; st_rd = 0; st_wr = 0; st_we = 0; st_last = 0; st_done_n = 0;
      st_last_addr = '0;
      @(negedge lmsm_clock);
      start = 1'b1; is_load = load; reg_list = list; base_addr = base;
      mem_ready = ready_seq[0];
      for (int c = 0; c < exp_q.size(); c++) begin
         @(negedge lmsm_clock);
         t = c + 1;
         e = exp_q[c];
         // While busy, start and the latched inputs must be ignored.
         if (e.busy && noisy) begin
            start = 1'($urandom_range(0, 1)); is_load = 1'($urandom);
            reg_list = 8'($urandom); base_addr = 16'($urandom);
         end else begin
            start = 1'b0;
         end
         mem_ready = ready_seq[t];
         mem_rdata = 16'($urandom);
         rf_rdata  = 16'($urandom);
         #1;
         check($sformatf("ctl{busy,done,rd,wr,we,last}@%0d", t),
               {26'd0, busy, done, mem_rd, mem_wr, rf_we, last},
               {26'd0, e.busy, e.done, e.rd, e.wr, e.we, e.last});
         check($sformatf("xfer_count@%0d", t), xfer_count, e.xfer);
         if (e.rd || e.wr) begin
            check($sformatf("mem_addr@%0d", t), mem_addr, e.addr);
            check($sformatf("rf_raddr@%0d", t), rf_raddr, e.idx);
            check($sformatf("rf_waddr@%0d", t), rf_waddr, e.idx);
            if (e.wr) check($sformatf("mem_wdata@%0d", t), mem_wdata, rf_rdata);
            if (e.rd) check($sformatf("rf_wdata@%0d", t), rf_wdata, mem_rdata);
         end
         if (mem_rd) st_rd++;
         if (mem_wr) st_wr++;
         if (rf_we) st_we++;
         if (last) st_last++;
         if ((mem_rd || mem_wr) && mem_ready) st_last_addr = mem_addr;
         if (done) begin st_done_n++; st_done_cyc = t; end
      end
      start = 1'b0;
   endtask

   typedef struct {
      bit          load;
      logic [7:0]  list;
      logic [15:0] base;
      int          done_cyc, n_rd, n_wr, n_we, n_last;
      logic [15:0] last_addr;
      logic [3:0]  xfer;
   } vec_t;

   vec_t vecs[5];

   initial begin : watchdog
      #500000;
      failures++;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0] = '{1'b1, 8'hFF, 16'h0040, 18, 8, 0, 8, 1, 16'h0047, 4'd8};
      vecs[1] = '{1'b0, 8'hA2, 16'h0100,  8, 0, 3, 0, 1, 16'h0102, 4'd3};
      vecs[2] = '{1'b1, 8'h00, 16'h1234,  2, 0, 0, 0, 0, 16'h0000, 4'd0};
      vecs[3] = '{1'b1, 8'h03, 16'hFFFF,  6, 2, 0, 2, 1, 16'h0000, 4'd2};
      vecs[4] = '{1'b0, 8'h80, 16'h0010,  4, 0, 1, 0, 1, 16'h0010, 4'd1};

      #12;
      check("reset_ctl", {busy, done, mem_rd, mem_wr, rf_we, last}, 6'b0);
      check("reset_addr", mem_addr, 16'h0);
      check("reset_xfer", xfer_count, 4'd0);
      check("reset_idx", rf_raddr, 3'd0);
      @(negedge lmsm_clock);
      lmsm_reset_n = 1'b1;

      // Directed table, ready tied high, start toggled while busy.
      fill_ready(1'b0);
      for (int v = 0; v < 5; v++) begin
         run_seq(vecs[v].load, vecs[v].list, vecs[v].base, 1'b1);
         check($sformatf("vec%0d_done_cycle", v), st_done_cyc, vecs[v].done_cyc);
         check($sformatf("vec%0d_done_pulses", v), st_done_n, 1);
         check($sformatf("vec%0d_reads", v), st_rd, vecs[v].n_rd);
         check($sformatf("vec%0d_writes", v), st_wr, vecs[v].n_wr);
         check($sformatf("vec%0d_rf_we", v), st_we, vecs[v].n_we);
         check($sformatf("vec%0d_last", v), st_last, vecs[v].n_last);
         if (vecs[v].n_rd + vecs[v].n_wr > 0)
            check($sformatf("vec%0d_final_addr", v), st_last_addr, vecs[v].last_addr);
         check($sformatf("vec%0d_xfer_idle", v), xfer_count, vecs[v].xfer);
      end

      // Single LM with three stall cycles before ready.
      fill_ready(1'b0);
      ready_seq[2] = 1'b0; ready_seq[3] = 1'b0; ready_seq[4] = 1'b0;
      run_seq(1'b1, 8'h01, 16'h0500, 1'b0);
      check("stall_done_cycle", st_done_cyc, 7);
      check("stall_read_cycles", st_rd, 4);
      check("stall_rf_we", st_we, 1);
      check("stall_last_cycles", st_last, 4);

      // Reset during the second access of an 8'hFF load.
      fill_ready(1'b0);
      @(negedge lmsm_clock);
      start = 1'b1; is_load = 1'b1; reg_list = 8'hFF; base_addr = 16'h0200; mem_ready = 1'b1;
      @(negedge lmsm_clock); start = 1'b0;
      repeat (3) @(negedge lmsm_clock);
      #1;
      check("pre_abort_rd", mem_rd, 1'b1);
      check("pre_abort_addr", mem_addr, 16'h0201);
      check("pre_abort_idx", rf_raddr, 3'd1);
      lmsm_reset_n = 1'b0;
      #1;
      check("abort_ctl", {busy, done, mem_rd, mem_wr, rf_we, last}, 6'b0);
      check("abort_addr", mem_addr, 16'h0);
      check("abort_xfer", xfer_count, 4'd0);
      check("abort_idx", rf_raddr, 3'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge lmsm_clock); #1;
         check($sformatf("abort_quiet@%0d", i), {busy, mem_rd, mem_wr, rf_we}, 4'b0);
      end
      @(negedge lmsm_clock);
      lmsm_reset_n = 1'b1;
      run_seq(1'b1, 8'h81, 16'h0300, 1'b1);
      check("post_abort_done_cycle", st_done_cyc, 6);
      check("post_abort_final_addr", st_last_addr, 16'h0301);

      // Random lists, directions, bases and ready patterns.
      for (int r = 0; r < 25; r++) begin
         fill_ready(1'b1);
         run_seq(1'($urandom), 8'($urandom), 16'($urandom), 1'b1);
         check($sformatf("rand%0d_done_pulses", r), st_done_n, 1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
